// File: rtl/lvds_rx_stream_arbiter.sv
// Merges the RX09 and RX24 LVDS sample streams into the shared RX FIFO.
// Each source has a 2-entry buffer, and the two buffers are drained round-robin.

module lvds_rx_src_buf #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_push,
    input  logic [31:0]      i_data,
    input  logic             i_pop,
    input  logic             i_cnt_clear,
    output logic [31:0]      o_head,
    output logic             o_nempty,
    output logic [CNT_W-1:0] o_ovf_cnt
);
    logic [31:0]      r_d0, r_d1;
    logic [1:0]       r_cnt;
    logic [CNT_W-1:0] r_ovf;
    logic             w_push, w_ovf;

    assign w_push    = i_push & i_en;
    // A pop on the same cycle frees a slot, so only a push without a pop overflows.
    assign w_ovf     = w_push & (r_cnt == 2'd2) & ~i_pop;
    assign o_head    = r_d0;
    assign o_nempty  = (r_cnt != 2'd0);
    assign o_ovf_cnt = r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            if (!i_en) begin
                r_cnt <= '0;
            end else begin
                case ({w_push, i_pop})
                    2'b10: begin
                        if (r_cnt == 2'd0) begin
                            r_d0  <= i_data;
                            r_cnt <= 2'd1;
                        end else if (r_cnt == 2'd1) begin
                            r_d1  <= i_data;
                            r_cnt <= 2'd2;
                        end
                    end
                    2'b01: begin
                        r_d0  <= r_d1;
                        r_cnt <= r_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (r_cnt == 2'd1) begin
                            r_d0 <= i_data;
                        end else begin
                            r_d0 <= r_d1;
                            r_d1 <= i_data;
                        end
                    end
                    default: ;
                endcase
            end
            if (i_cnt_clear)
                r_ovf <= {{(CNT_W-1){1'b0}}, w_ovf};
            else if (w_ovf && (r_ovf != {CNT_W{1'b1}}))
                r_ovf <= r_ovf + 1'b1;
        end
    end
endmodule

module lvds_rx_stream_arbiter #(
    parameter int TAG_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode,
    input  logic             i_cnt_clear,
    input  logic             i_rx09_push,
    input  logic [31:0]      i_rx09_data,
    input  logic             i_rx24_push,
    input  logic [31:0]      i_rx24_data,
    input  logic             i_fifo_full,
    output logic             o_fifo_push,
    output logic [31:0]      o_fifo_data,
    output logic [CNT_W-1:0] o_ovf09_cnt,
    output logic [CNT_W-1:0] o_ovf24_cnt,
    output logic             o_last_src,
    output logic [1:0]       o_debug_state
);
    logic        r_push, r_last;
    logic [31:0] r_data;
    logic [31:0] w_head09, w_head24, w_word;
    logic        w_ne09, w_ne24, w_el09, w_el24, w_gnt09, w_gnt24;

    lvds_rx_src_buf #(.CNT_W(CNT_W)) u_buf09 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_mode[0]),
        .i_push(i_rx09_push), .i_data(i_rx09_data), .i_pop(w_gnt09),
        .i_cnt_clear(i_cnt_clear), .o_head(w_head09), .o_nempty(w_ne09),
        .o_ovf_cnt(o_ovf09_cnt)
    );

    lvds_rx_src_buf #(.CNT_W(CNT_W)) u_buf24 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_mode[1]),
        .i_push(i_rx24_push), .i_data(i_rx24_data), .i_pop(w_gnt24),
        .i_cnt_clear(i_cnt_clear), .o_head(w_head24), .o_nempty(w_ne24),
        .o_ovf_cnt(o_ovf24_cnt)
    );

    assign w_el09 = i_mode[0] & w_ne09 & ~i_fifo_full;
    assign w_el24 = i_mode[1] & w_ne24 & ~i_fifo_full;
    // On a tie the source that did not win last time gets the grant.
    assign w_gnt09 = w_el09 & (~w_el24 | r_last);
    assign w_gnt24 = w_el24 & (~w_el09 | ~r_last);

    always_comb begin
        w_word = w_gnt24 ? w_head24 : w_head09;
        if ((TAG_EN != 0) && (i_mode == 2'b11))
            w_word[30] = w_gnt24;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_push <= 1'b0;
            r_data <= '0;
            r_last <= 1'b1;
        end else begin
            r_push <= w_gnt09 | w_gnt24;
            if (w_gnt09 | w_gnt24) begin
                r_data <= w_word;
                r_last <= w_gnt24;
            end
        end
    end

    assign o_fifo_push   = r_push;
    assign o_fifo_data   = r_data;
    assign o_last_src    = r_last;
    assign o_debug_state = {w_ne24, w_ne09};
endmodule

// File: tb/tb_lvds_rx_stream_arbiter.sv
// Scoreboard bench for lvds_rx_stream_arbiter: expected FIFO words are queued at
// stimulus time and matched by a negedge monitor; per-scenario tasks check the rest.

module tb_lvds_rx_stream_arbiter;
    logic        clk = 1'b0;
    logic        rst, cnt_clear, p09, p24, full;
    logic [1:0]  mode;
    logic [31:0] d09, d24;
    logic        fpush, last_src;
    logic [31:0] fdata;
    logic [15:0] ovf09, ovf24;
    logic [1:0]  dbg;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    lvds_rx_stream_arbiter #(.TAG_EN(1), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_cnt_clear(cnt_clear),
        .i_rx09_push(p09), .i_rx09_data(d09), .i_rx24_push(p24), .i_rx24_data(d24),
        .i_fifo_full(full), .o_fifo_push(fpush), .o_fifo_data(fdata),
        .o_ovf09_cnt(ovf09), .o_ovf24_cnt(ovf24), .o_last_src(last_src),
        .o_debug_state(dbg)
    );

    always #5 clk = ~clk;

    // Every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (fpush) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got push data=%h, expected no push", fdata);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (fdata !== exp) begin
                    failures++;
                    $display("FAIL sb_data: got %h expected %h", fdata, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mode = 2'b00; cnt_clear = 1'b0; p09 = 1'b0; p24 = 1'b0;
        d09 = '0; d24 = '0; full = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fpush, fdata, ovf09, ovf24, last_src, dbg} !== {1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL reset_state: got push=%b data=%h o9=%h o24=%h last=%b dbg=%b, expected 0/0/0/0/1/00",
                     fpush, fdata, ovf09, ovf24, last_src, dbg);
        end
    endtask

    task automatic test_mode01();
        do_reset();
        mode = 2'b01;
        for (int n = 1; n <= 4; n++) begin
            p09 = 1'b1; d09 = 32'h8000_0000 + n;
            sb.push_back(d09);
            tick();
            p09 = 1'b0;
            checks++;
            if (fpush !== 1'b0) begin
                failures++;
                $display("FAIL m01_early: word %0d push=%b expected 0 one cycle after input", n, fpush);
            end
            tick();
            checks++;
            if (fpush !== 1'b1 || fdata !== 32'h8000_0000 + n) begin
                failures++;
                $display("FAIL m01_latency: word %0d push=%b data=%h expected 1/%h", n, fpush, fdata, 32'h8000_0000 + n);
            end
        end
        tick();
        checks++;
        if (sb.size() != 0 || ovf09 !== 16'h0 || ovf24 !== 16'h0) begin
            failures++;
            $display("FAIL m01_end: pending=%0d o9=%h o24=%h expected 0/0/0", sb.size(), ovf09, ovf24);
        end
    endtask

    task automatic test_interleave();
        int outs;
        outs = 0;
        do_reset();
        mode = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (c < 8 && (c % 2) == 0) begin
                p09 = 1'b1; d09 = 32'h8000_0000 + c / 2;
                p24 = 1'b1; d24 = 32'h8000_1000 + c / 2;
                sb.push_back(d09);
                sb.push_back(d24 | 32'h4000_0000);
            end else begin
                p09 = 1'b0; p24 = 1'b0;
            end
            tick();
            if (fpush) begin
                checks++;
                if (last_src !== outs[0]) begin
                    failures++;
                    $display("FAIL il_last_src: output %0d last_src=%b expected %b", outs, last_src, outs[0]);
                end
                outs++;
            end
        end
        checks++;
        if (outs != 8 || sb.size() != 0) begin
            failures++;
            $display("FAIL il_count: outputs=%0d pending=%0d expected 8/0", outs, sb.size());
        end
    endtask

    task automatic test_full_overflow();
        do_reset();
        mode = 2'b01; full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            p09 = 1'b1; d09 = 32'h0000_0A00 + n;
            if (n < 2) sb.push_back(d09);
            tick();
            checks++;
            if (fpush !== 1'b0) begin
                failures++;
                $display("FAIL full_push: push=%b expected 0 while full", fpush);
            end
        end
        p09 = 1'b0;
        tick();
        checks++;
        if (ovf09 !== 16'd3 || dbg !== 2'b01) begin
            failures++;
            $display("FAIL full_ovf: o9=%h dbg=%b expected 0003/01", ovf09, dbg);
        end
        full = 1'b0;
        tick();
        tick();
        checks++;
        if (fpush !== 1'b1) begin
            failures++;
            $display("FAIL full_drain2: push=%b expected 1 on second consecutive cycle", fpush);
        end
        tick();
        checks++;
        if (fpush !== 1'b0 || sb.size() != 0 || dbg !== 2'b00) begin
            failures++;
            $display("FAIL full_drain_end: push=%b pending=%0d dbg=%b expected 0/0/00", fpush, sb.size(), dbg);
        end
    endtask

    task automatic test_counter_sat();
        do_reset();
        mode = 2'b10; full = 1'b1; p24 = 1'b1; d24 = 32'h1234_5678;
        for (int n = 0; n < 2 + 16'hFFFE; n++) tick();
        checks++;
        if (ovf24 !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload: o24=%h expected fffe", ovf24);
        end
        for (int n = 0; n < 3; n++) tick();
        checks++;
        if (ovf24 !== 16'hFFFF || ovf09 !== 16'h0) begin
            failures++;
            $display("FAIL sat_hold: o24=%h o9=%h expected ffff/0000", ovf24, ovf09);
        end
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0; p24 = 1'b0;
        checks++;
        if (ovf24 !== 16'h0001) begin
            failures++;
            $display("FAIL sat_clear_ovf: o24=%h expected 0001", ovf24);
        end
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        checks++;
        if (ovf24 !== 16'h0000) begin
            failures++;
            $display("FAIL sat_clear: o24=%h expected 0000", ovf24);
        end
        mode = 2'b00;
        tick();
        full = 1'b0;
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 2'b11; full = 1'b1;
        for (int n = 0; n < 2; n++) begin
            p09 = 1'b1; d09 = 32'h0000_0900 + n;
            p24 = 1'b1; d24 = 32'h8000_1000 + n;
            sb.push_back(d24);
            tick();
        end
        p09 = 1'b0; p24 = 1'b0;
        checks++;
        if (dbg !== 2'b11) begin
            failures++;
            $display("FAIL sw_loaded: dbg=%b expected 11", dbg);
        end
        mode = 2'b10;
        tick();
        checks++;
        if (dbg !== 2'b10) begin
            failures++;
            $display("FAIL sw_flush: dbg=%b expected 10", dbg);
        end
        full = 1'b0;
        for (int n = 0; n < 4; n++) begin
            p09 = 1'b1; d09 = 32'h0000_0950 + n;
            tick();
        end
        p09 = 1'b0;
        checks++;
        if (dbg[0] !== 1'b0 || ovf09 !== 16'h0 || sb.size() != 0) begin
            failures++;
            $display("FAIL sw_ignore: dbg=%b o9=%h pending=%0d expected x0/0000/0", dbg, ovf09, sb.size());
        end
        p24 = 1'b1; d24 = 32'h8000_1007;
        sb.push_back(d24);
        tick();
        p24 = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sw_drain: pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 2'b11; full = 1'b1;
        for (int n = 0; n < 2; n++) begin
            p09 = 1'b1; d09 = 32'h0000_0C00 + n;
            p24 = 1'b1; d24 = 32'h0000_0D00 + n;
            tick();
        end
        p09 = 1'b0; p24 = 1'b0; full = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (fpush !== 1'b0 || dbg !== 2'b00 || last_src !== 1'b1 || fdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: push=%b dbg=%b last=%b data=%h expected 0/00/1/0", fpush, dbg, last_src, fdata);
        end
        p09 = 1'b1; d09 = 32'h0000_0E00;
        p24 = 1'b1; d24 = 32'h0000_0F00;
        sb.push_back(d09);
        sb.push_back(d24 | 32'h4000_0000);
        tick();
        p09 = 1'b0; p24 = 1'b0;
        tick();
        checks++;
        if (fpush !== 1'b1 || last_src !== 1'b0) begin
            failures++;
            $display("FAIL rst_first_tie: push=%b last=%b expected 1/0", fpush, last_src);
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rst_drain: pending=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; cnt_clear = 1'b0; p09 = 1'b0; p24 = 1'b0;
        d09 = '0; d24 = '0; full = 1'b0;
        test_reset();
        test_mode01();
        test_interleave();
        test_full_overflow();
        test_counter_sat();
        test_mode_switch();
        test_reset_mid();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lvds_rx_stream_arbiter.md
Name: lvds_rx_stream_arbiter

Overview:
- Merges the 32-bit sample words of the two LVDS receiver instances (RX09 = sub-GHz, RX24 = 2.4 GHz) into the single shared RX sample FIFO.
- Each source has a 2-entry buffer. The buffers are drained round-robin into the FIFO write port, subject to a mode select.
- The receivers cannot be back-pressured. Overflow therefore drops the incoming word and is counted per source.
- Sits between the lvds receivers and the RX FIFO, in the receivers' write-clock domain.

Parameters:
- TAG_EN, 1, when 1 and mode is 2'b11, bit 30 of each output word is replaced with the source id (0 = RX09, 1 = RX24). Otherwise words pass unmodified.
- CNT_W, 16, width of each saturating overflow counter.

Ports:
- i_clk  in  1  single clock for the whole block. All inputs are synchronous to it.
- i_rst  in  1  synchronous reset, active-high.
- i_mode  in  2  00 = off, 01 = RX09 only, 10 = RX24 only, 11 = both interleaved.
- i_cnt_clear  in  1  single-cycle pulse that clears both overflow counters.
- i_rx09_push  in  1  RX09 word valid, 1-cycle strobe.
- i_rx09_data  in  32  RX09 word.
- i_rx24_push  in  1  RX24 word valid.
- i_rx24_data  in  32  RX24 word.
- i_fifo_full  in  1  shared FIFO full flag.
- o_fifo_push  out  1  FIFO write strobe, registered.
- o_fifo_data  out  32  FIFO write data, registered.
- o_ovf09_cnt  out  CNT_W  RX09 dropped-word count, saturating.
- o_ovf24_cnt  out  CNT_W  RX24 dropped-word count, saturating.
- o_last_src  out  1  source of the most recent grant.
- o_debug_state  out  2  buffer occupancy summary: {RX24 non-empty, RX09 non-empty}.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - Both buffers are emptied.
  - o_fifo_push=0, o_fifo_data=0, both counters=0, o_last_src=1 (so RX09 wins the first tie), o_debug_state=2'b00.
- Source enable:
  - RX09 is enabled when i_mode[0]=1; RX24 is enabled when i_mode[1]=1.
  - A push from a disabled source is ignored and is not counted.
  - On any cycle where a source is disabled, its buffer is flushed to empty. This applies both to mode changes and to mode held at 00.
- Buffers:
  - Each buffer is a 2-entry in-order FIFO.
  - A push into a full buffer drops the incoming word and increments that source's counter.
  - A push on the same cycle as a read from a full buffer is accepted and does not count as an overflow.
- Grant, evaluated every cycle when i_fifo_full=0:
  - Eligible sources: enabled with a non-empty buffer.
  - If exactly one source is eligible, it is granted.
  - If both are eligible, the source not equal to o_last_src is granted.
  - On a grant:
    - The head entry is popped.
    - Next cycle, o_fifo_push=1 and o_fifo_data = head word, with bit 30 tagged if TAG_EN and mode=11.
    - o_last_src is updated.
  - If there is no grant, or i_fifo_full=1: o_fifo_push=0 next cycle, o_fifo_data holds its value, and buffers are not popped.
- Throughput and latency:
  - At most one word per cycle is written to the FIFO.
  - Minimum latency from a push into an empty buffer to o_fifo_push is 2 cycles: buffered at edge N, granted and registered at edge N+1.
- Counters:
  - Saturate at all-ones.
  - i_cnt_clear has priority over increment. If an overflow coincides with a clear, the counter loads 1.
- Reset mid-operation: any buffered words are discarded. No FIFO push occurs on the cycle after the reset edge.

Test Plan:
- Mode 01, RX09 pushes words 0x80000001..0x80000004 on alternate cycles, fifo not full -> 4 FIFO pushes in order, each 2 cycles after its input push, data unmodified, counters 0.
- Mode 11 with TAG_EN=1, RX09 and RX24 both push every 2nd cycle (RX09 0x80000000+n, RX24 0x80001000+n) -> output alternates RX09, RX24, ...; RX24 words have bit30=1, RX09 words bit30=0; o_last_src toggles.
- Mode 01, i_fifo_full held 1, RX09 pushes 5 words -> no FIFO push, buffer keeps the first 2 words, o_ovf09_cnt=3. Release full -> exactly those 2 words are pushed on consecutive cycles.
- Preload o_ovf24_cnt to 0xFFFE by 0xFFFE overflows, cause 3 more overflows -> counter = 0xFFFF. Pulse i_cnt_clear together with 1 overflow -> counter = 1.
- Mode 11 with both buffers holding words, switch to mode 10 -> RX09 buffer flushed. Only RX24 words are output afterwards, and RX09 pushes are neither buffered nor counted.
- i_rst asserted for 1 cycle while both buffers are full and a grant is pending -> o_fifo_push=0 the next cycle and o_debug_state=00. The next pushes are output normally, and RX09 wins the first tie.
